booth_seq_ctrl: RTL and testbench

//   Sequential radix-2 Booth multiplier with its controlling FSM: accepts a signed

---
 rtl/booth_seq_ctrl_pkg.sv | 28 ++
 rtl/booth_seq_ctrl_if.sv | 26 ++
 rtl/booth_step.sv | 32 +++
 rtl/booth_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_booth_seq_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/booth_seq_ctrl_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, Booth step
// opcodes and the radix-2 recoding decode.
package booth_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the multiplier bit pair {q[0], q_m1}
    function automatic booth_op_t booth_decode(input logic [1:0] pair);
        booth_op_t op;
        case (pair)
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Operand/product handshake bundle for booth_seq_ctrl; the master side is the
// producer/consumer, the slave side is the multiplier.
interface booth_seq_ctrl_if #(
    parameter int WIDTH = 4
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of the
// multiplicand followed by an arithmetic right shift of {acc, q, q_m1}.
module booth_step
    import booth_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   m,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case (booth_decode({q[0], q_m1}))
            OP_ADD:  sum = acc + m;
            OP_SUB:  sum = acc - m;
            default: sum = acc;
        endcase
    end

    assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_next    = {sum[0], q[WIDTH-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier with handshake FSM, one step per clock.
// Optional macro BOOTH_EARLY_TERM_EN finishes early once the remaining steps are no-ops.
module booth_seq_ctrl
    import booth_seq_ctrl_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    booth_seq_ctrl_if.slave  bus
);

    state_t               state;
    logic [WIDTH:0]       m;
    logic [WIDTH:0]       acc;
    logic [WIDTH-1:0]     q;
    logic                 q_m1;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   product;
    logic                 in_ready;
    logic                 out_valid;
    logic                 busy;

    logic [WIDTH:0]       acc_next;
    logic [WIDTH-1:0]     q_next;
    logic                 q_m1_next;
    logic                 finish;
    logic [2*WIDTH-1:0]   product_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .m         (m),
        .acc       (acc),
        .q         (q),
        .q_m1      (q_m1),
        .acc_next  (acc_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic               tail_same;
    logic [2*WIDTH:0]   full_next;

    // After this step the pending multiplier bits are q[cnt-1:1] and the new
    // q_m1 is q[0]; if they all agree, every later step is a plain shift.
    always_comb begin
        tail_same = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            if ((CNT_W'(i) < cnt) && (q[i] != q[0])) begin
                tail_same = 1'b0;
            end
        end
        finish       = (cnt == CNT_W'(1)) || tail_same;
        full_next    = $signed({acc_next, q_next}) >>> (cnt - CNT_W'(1));
        product_next = full_next[2*WIDTH-1:0];
    end
`else
    assign finish       = (cnt == CNT_W'(1));
    assign product_next = {acc_next[WIDTH-1:0], q_next};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            m         <= '0;
            acc       <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            product   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        m        <= {bus.a[WIDTH-1], bus.a};
                        acc      <= '0;
                        q        <= bus.b;
                        q_m1     <= 1'b0;
                        cnt      <= CNT_W'(WIDTH);
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    q    <= q_next;
                    q_m1 <= q_m1_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (finish) begin
                        product   <= product_next;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.product   = product;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl (WIDTH=4): products come from plain a*b,
// a decoupled monitor pops expectations whenever a product is retired.
module tb_booth_seq_ctrl;

    localparam int WIDTH = 4;
`ifdef BOOTH_EARLY_TERM_EN
    localparam int DEF_LAT = 0;
`else
    localparam int DEF_LAT = WIDTH;
`endif

    typedef struct {
        logic [2*WIDTH-1:0] prod;
        int                 lat;
        int                 acc_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    int   ready_mode;
    exp_t exp_q[$];

    booth_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    booth_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one operand pair, hold it until accepted, then log the reference product.
    task automatic applyStimulus(input logic signed [WIDTH-1:0] av,
                                 input logic signed [WIDTH-1:0] bv,
                                 input int gap, input int lat);
        int   waited;
        int   p;
        exp_t e;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_timeout", 32'(waited < 100), 32'd1);
        @(posedge clk);
        #1;
        p         = int'(av) * int'(bv);
        e.prod    = p[2*WIDTH-1:0];
        e.lat     = lat;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        bus.in_valid = 1'b0;
        bus.a        = WIDTH'($urandom);
        bus.b        = WIDTH'($urandom);
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // out_ready: 0 = random, 1 = held low, 2 = held high
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = ($urandom_range(0, 3) != 0);
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
        endcase
    end

    // Monitor: latency on each new product, stability while stalled, compare on retire.
    logic               prev_valid;
    logic               prev_taken;
    logic [2*WIDTH-1:0] prev_product;
    initial begin
        prev_valid   = 1'b0;
        prev_taken   = 1'b0;
        prev_product = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid && prev_taken) begin
                checkOutput("valid_after_take", 32'(bus.out_valid), 32'd0);
            end
            if (bus.out_valid) begin
                if (!prev_valid) begin
                    checkOutput("pending_exp", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        if (exp_q[0].lat > 0) begin
                            checkOutput("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(exp_q[0].lat));
                        end else begin
                            checkOutput("latency_range",
                                        32'((cyc - exp_q[0].acc_cyc) >= 1 && (cyc - exp_q[0].acc_cyc) <= WIDTH),
                                        32'd1);
                        end
                    end
                end else if (!prev_taken) begin
                    checkOutput("product_stable", 32'(bus.product), 32'(prev_product));
                end
                if (bus.out_ready && exp_q.size() != 0) begin
                    checkOutput("product", 32'(bus.product), 32'(exp_q[0].prod));
                    void'(exp_q.pop_front());
                end
                prev_taken = bus.out_ready;
            end else begin
                prev_taken = 1'b0;
            end
        end else begin
            prev_taken = 1'b0;
        end
        prev_valid   = bus.out_valid && rst_n;
        prev_product = bus.product;
    end

    initial begin
        int w;
        checks        = 0;
        errors        = 0;
        ready_mode    = 2;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_product", 32'(bus.product), 32'd0);

        $display("[TB] directed operand pairs");
        applyStimulus(4'sd3, -4'sd2, 0, WIDTH);
        applyStimulus(-4'sd8, -4'sd8, 1, DEF_LAT);
        applyStimulus(4'sd7, -4'sd8, 0, DEF_LAT);
        applyStimulus(-4'sd8, 4'sd7, 2, DEF_LAT);
`ifdef BOOTH_EARLY_TERM_EN
        applyStimulus(4'sd5, 4'sd0, 0, 1);
        applyStimulus(4'sd5, -4'sd1, 0, 1);
`endif
        waitDrain();

        $display("[TB] out_ready held low in DONE");
        ready_mode = 1;
        applyStimulus(4'sd5, -4'sd3, 0, DEF_LAT);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("hold_wait_timeout", 32'(w < 50), 32'd1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_product", 32'(bus.product), 32'(8'hF1));
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("hold_busy", 32'(bus.busy), 32'd1);
        end
        ready_mode = 2;
        waitDrain();

        $display("[TB] reset mid-RUN");
        ready_mode = 1;
        applyStimulus(-4'sd7, 4'sd6, 0, DEF_LAT);
        @(negedge clk);
        checkOutput("midrun_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("midrun_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrun_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrun_product", 32'(bus.product), 32'd0);
        checkOutput("midrun_busy_clr", 32'(bus.busy), 32'd0);
        ready_mode = 2;
        applyStimulus(-4'sd7, 4'sd6, 0, DEF_LAT);
        waitDrain();

        $display("[TB] all operand pairs, random gaps and back-pressure");
        ready_mode = 0;
        for (int ai = -8; ai < 8; ai++) begin
            for (int bi = -8; bi < 8; bi++) begin
                applyStimulus(WIDTH'(ai), WIDTH'(bi), int'($urandom_range(0, 2)), DEF_LAT);
            end
        end
        waitDrain();
        ready_mode = 2;
        repeat (WIDTH + 4) @(negedge clk);
        checkOutput("no_extra_output", 32'(bus.out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
